slew_array: RTL and testbench
=============================

# slew_array

Multi-channel, time-multiplexed slew-rate limiter: each of `nch` outputs moves towards its own set point by at most a programmable step per tick, with per-channel wrap (phase) and bypass modes. One shared arithmetic path serves all channels in a round-robin sweep started by `tick`. The block feeds DAC/phase-shifter set points in the LLRF control path, replacing single-channel unit-step slew limiters.

## Interface
- `dw`, 16: value width per channel
- `nch`, 4: channel count, 1–64
- `sw`, 8: step-size width, `sw` ≤ `dw`
- `clk`  in  1: system clock
- `rst`  in  1: synchronous, active-high reset
- `in_set`  in  `nch*dw`: set points, channel k at bits `[k*dw +: dw]`
- `step`  in  `nch*sw`: unsigned max step per tick, channel k at `[k*sw +: sw]`
- `enable`  in  `nch`: 0 = channel bypass (output jumps to set point at its slot)
- `wrap`  in  `nch`: 1 = modular (phase) arithmetic
- `tick`  in  1: start one sweep over all channels
- `out_val`  out  `nch*dw`: current outputs, same packing as `in_set`
- `motion`  out  `nch`: channel k has not reached its set point
- `busy`  out  1: sweep in progress
- `overrun`  out  1: sticky, a tick arrived while busy

## Operation
- Reset: all `out_val` = 0, `motion` = 0, `busy` = 0, `overrun` = 0, sweep index = 0.
- Idle state: `tick`=1 and `busy`=0 starts a sweep; `busy` goes high.
- Sweep: channels processed in order 0..nch-1, one per cycle, two-stage pipe (A: select channel, compute diff; B: write `out_val[k]`, `motion[k]`).
- `in_set`, `step`, `enable`, `wrap` for channel k sampled in its stage-A cycle only; changes at other times are ignored until the next sweep.
- diff = in_set − current, `dw+1` bits.
  - wrap=0: direction = diff[dw], magnitude = |diff| as `dw+1`-bit signed.
  - wrap=1: diff reduced mod 2^dw, direction = diff[dw-1], magnitude = |diff| as `dw`-bit signed; diff = −2^(dw-1) moves downward.
- Update when enable=1: magnitude ≤ step → current = in_set (no overshoot); else current ± step, mod 2^dw when wrap=1. A non-wrap channel never crosses 0 or 2^dw−1.
- Update when enable=0: current = in_set.
- step = 0 with enable=1: channel holds its value; `motion` reflects the mismatch.
- `motion[k]` = (new current ≠ sampled in_set), written with `out_val[k]`.
- `tick` while `busy`=1 is dropped and sets `overrun`. Only `rst` clears `overrun`.
- `rst` mid-sweep aborts the sweep. Channels already written return to 0 with the rest.

## Timing
- Tick sampled at cycle t → `busy`=1 in cycles t+1 … t+nch+1.
- Channel k stage A in cycle t+1+k. New `out_val[k]`/`motion[k]` visible from cycle t+2+k.
- Minimum accepted tick spacing: nch+2 cycles. A tick at cycle t+nch+2 is accepted.
- Tick in the last busy cycle (t+nch+1) is an overrun.
- Outputs are registered and hold between sweeps.

## Structure
- Shared package `slew_pkg`: packing helper functions (channel slice offsets) and the encoding of diff direction/magnitude. No state types are needed beyond idle/sweeping.
- One sub-module, `slew_step`: combinational per-slot computation. Inputs: current, set, step, enable, wrap. Outputs: next value and motion. Instantiated once between stage A and stage B.
- Top level holds the sweep counter, pipeline registers, output register file and overrun flag.

## Test plan
- Reset then one tick with nch=4, dw=16, step=8 for all channels, sets {20,0,65530,5}, wrap=0 → outputs {8,0,8,5}. Motion {1,0,1,0}. `busy` high for 5 cycles.
- Channel 0 wrap=1, current 65530, set 4, step 4 → per tick 65534, 2, 4. Motion clears at 4. The same case with wrap=0 climbs downward 65526, ….
- Per-channel latency: tick at t → `out_val[k]` changes exactly at t+2+k. Ticks spaced nch+1 apart set `overrun`. Ticks spaced nch+2 apart do not.
- enable=0 on channel 2 with set 1234 → out 1234 after one tick, motion 0. step=0 with set ≠ current → output holds, motion stays 1.
- Overshoot check: current 100, set 103, step 8 → 103. Wrap half-range tie: current 0, set 32768 → moves downward to 65528.
- Assert `rst` in cycle t+2 of a sweep → all outputs 0, `busy` 0 next cycle. A following tick behaves as after power-up.

Source files
------------

// File: rtl/slew_pkg.sv
// -----------------------------------------------------------------------------
// slew_pkg
// Shared definitions for the time-multiplexed slew-rate limiter:
//   - sweep_state_e : sweep sequencer states (idle / sweeping)
//   - dir_e         : encoding of the diff direction bit
//   - ch_lo()       : low bit offset of a channel slice in a packed bus
//   - idx_width()   : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package slew_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    // The sign bit of the set-minus-current difference selects the direction:
    // a clear sign bit means the set point lies above the current value.
    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Low bit of channel ch in a bus packing channels of the given width.
    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

    // Channel index width; a single-channel array still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/slew_step.sv
// -----------------------------------------------------------------------------
// slew_step
// Combinational per-slot update of one channel: moves the current value
// towards the set point by at most `step`, without overshoot.
// Ports:
//   current  in  dw     value held in the output register for this channel
//   set      in  dw     sampled set point
//   step     in  sw     unsigned maximum move per tick
//   enable   in  1      0 = bypass, result is the set point
//   wrap     in  1      1 = modular (phase) arithmetic on dw bits
//   diff     in  dw+1   set - current, computed in the selecting stage
//   next_val out dw     updated channel value
//   motion   out 1      updated value still differs from the set point
// -----------------------------------------------------------------------------
module slew_step
    import slew_pkg::*;
#(
    parameter int dw = 16,
    parameter int sw = 8
) (
    input  logic [dw-1:0] current,
    input  logic [dw-1:0] set,
    input  logic [sw-1:0] step,
    input  logic          enable,
    input  logic          wrap,
    input  logic [dw:0]   diff,
    output logic [dw-1:0] next_val,
    output logic          motion
);

    dir_e        dir_s;
    logic [dw:0] mag_s;
    logic [dw:0] step_ext_s;

    // Direction and magnitude of the distance to the set point.
    // In wrap mode the diff is taken mod 2^dw, so its top bit is the sign and
    // the half-range tie (-2^(dw-1)) is treated as a downward move.
    always_comb begin
        step_ext_s = (dw+1)'(step);
        dir_s      = DIR_UP;
        mag_s      = '0;
        if (wrap) begin
            dir_s = dir_e'(diff[dw-1]);
            if (dir_s == DIR_DOWN) begin
                mag_s = {1'b0, (~diff[dw-1:0]) + dw'(1)};
            end else begin
                mag_s = {1'b0, diff[dw-1:0]};
            end
        end else begin
            dir_s = dir_e'(diff[dw]);
            if (dir_s == DIR_DOWN) begin
                mag_s = (~diff) + (dw+1)'(1);
            end else begin
                mag_s = diff;
            end
        end
    end

    // New value: snap to the set point when within one step, otherwise move by
    // exactly one step. A non-wrap channel cannot leave [0, 2^dw-1] because it
    // only moves by step when the set point is more than a step away.
    always_comb begin
        next_val = set;
        if (!enable) begin
            next_val = set;
        end else if (mag_s <= step_ext_s) begin
            next_val = set;
        end else if (dir_s == DIR_DOWN) begin
            next_val = current - dw'(step);
        end else begin
            next_val = current + dw'(step);
        end
        motion = (next_val != set);
    end

endmodule

// File: rtl/slew_array.sv
// -----------------------------------------------------------------------------
// slew_array
// Multi-channel slew-rate limiter with one shared arithmetic path. A tick in
// idle starts a sweep that visits channels 0..nch-1, one per cycle. In a
// channel's selection cycle its inputs are sampled, the diff is formed, and
// slew_step produces the value that is written into the output register file
// at the end of that cycle. Busy stays high one extra cycle so that it covers
// the cycle in which the last channel's new value first becomes visible.
// Ports:
//   clk      in  1        system clock
//   rst      in  1        synchronous active-high reset
//   in_set   in  nch*dw   set points, channel k at [k*dw +: dw]
//   step     in  nch*sw   max step per tick, channel k at [k*sw +: sw]
//   enable   in  nch      0 = channel bypass
//   wrap     in  nch      1 = modular (phase) arithmetic
//   tick     in  1        start one sweep
//   out_val  out nch*dw   current outputs
//   motion   out nch      channel has not reached its set point
//   busy     out 1        sweep in progress
//   overrun  out 1        sticky: tick seen while busy
// -----------------------------------------------------------------------------
module slew_array
    import slew_pkg::*;
#(
    parameter int dw  = 16,
    parameter int nch = 4,
    parameter int sw  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [nch*dw-1:0] in_set,
    input  logic [nch*sw-1:0] step,
    input  logic [nch-1:0]    enable,
    input  logic [nch-1:0]    wrap,
    input  logic              tick,
    output logic [nch*dw-1:0] out_val,
    output logic [nch-1:0]    motion,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned IW = idx_width(nch);
    localparam logic [IW-1:0] LAST_IDX = IW'(nch - 1);

    sweep_state_e  state_r;
    logic [IW-1:0] idx_r;
    logic          busy_r;
    logic          drain_r;
    logic          overrun_r;
    logic [dw-1:0] out_r [nch];
    logic [nch-1:0] motion_r;

    logic [dw-1:0] a_cur_s;
    logic [dw-1:0] a_set_s;
    logic [sw-1:0] a_step_s;
    logic          a_en_s;
    logic          a_wrap_s;
    logic [dw:0]   a_diff_s;
    logic [dw-1:0] next_s;
    logic          motion_s;

    // Selection stage: pick the channel under the sweep index and form the
    // dw+1-bit difference so the non-wrap sign is never lost.
    always_comb begin
        a_cur_s  = out_r[idx_r];
        a_set_s  = in_set[ch_lo(32'(idx_r), 32'(dw)) +: dw];
        a_step_s = step[ch_lo(32'(idx_r), 32'(sw)) +: sw];
        a_en_s   = enable[idx_r];
        a_wrap_s = wrap[idx_r];
        a_diff_s = {1'b0, a_set_s} - {1'b0, a_cur_s};
    end

    slew_step #(
        .dw (dw),
        .sw (sw)
    ) u_step (
        .current  (a_cur_s),
        .set      (a_set_s),
        .step     (a_step_s),
        .enable   (a_en_s),
        .wrap     (a_wrap_s),
        .diff     (a_diff_s),
        .next_val (next_s),
        .motion   (motion_s)
    );

    // Sweep sequencer: accepts a tick only when fully idle, walks the channel
    // index, then holds busy for one drain cycle after the last channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            drain_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drain_r <= 1'b0;
                    if (drain_r) begin
                        busy_r <= 1'b0;
                    end else if (tick && !busy_r) begin
                        state_r <= ST_SWEEP;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r <= busy_r;
                    end
                end
                ST_SWEEP: begin
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_IDLE;
                        idx_r   <= '0;
                        drain_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                    drain_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun flag: a tick that lands while busy is dropped and noted.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (tick && busy_r) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // Output register file: the selected channel is rewritten once per sweep;
    // all other channels hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < nch; i++) begin
                out_r[i] <= '0;
            end
            motion_r <= '0;
        end else if (state_r == ST_SWEEP) begin
            out_r[idx_r]    <= next_s;
            motion_r[idx_r] <= motion_s;
        end else begin
            motion_r <= motion_r;
        end
    end

    for (genvar g = 0; g < nch; g++) begin : g_pack
        assign out_val[g*dw +: dw] = out_r[g];
    end

    assign motion  = motion_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_slew_array.sv
// -----------------------------------------------------------------------------
// tb_slew_array
// Directed and randomized checks of slew_array against a behavioural model
// that applies the slewing rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_slew_array;

    localparam int DW   = 16;
    localparam int NCH  = 4;
    localparam int SW   = 8;
    localparam int FULL = 1 << DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] in_set;
    logic [NCH*SW-1:0] step_v;
    logic [NCH-1:0]    enable_v;
    logic [NCH-1:0]    wrap_v;
    logic              tick;
    logic [NCH*DW-1:0] out_val;
    logic [NCH-1:0]    motion;
    logic              busy;
    logic              overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    int model_out [NCH];
    bit model_mot [NCH];
    bit model_ovr;

    slew_array #(.dw(DW), .nch(NCH), .sw(SW)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_set  (in_set),
        .step    (step_v),
        .enable  (enable_v),
        .wrap    (wrap_v),
        .tick    (tick),
        .out_val (out_val),
        .motion  (motion),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_out(input int k);
        return int'(out_val[k*DW +: DW]);
    endfunction

    // Reference rule: distance to the set point (shortest signed distance in
    // wrap mode, half-range tie counted as downward), snap when within a step.
    function automatic int model_next(input int cur, input int sp, input int st,
                                      input bit en, input bit wr);
        int d;
        int r;
        if (!en) return sp;
        d = sp - cur;
        if (wr) begin
            d = ((d % FULL) + FULL) % FULL;
            if (d >= FULL / 2) d = d - FULL;
        end
        if (((d < 0) ? -d : d) <= st) return sp;
        r = (d > 0) ? cur + st : cur - st;
        if (wr) r = ((r % FULL) + FULL) % FULL;
        return r;
    endfunction

    task automatic set_ch(input int k, input int sp, input int st, input bit en, input bit wr);
        in_set[k*DW +: DW] = DW'(sp);
        step_v[k*SW +: SW] = SW'(st);
        enable_v[k]        = en;
        wrap_v[k]          = wr;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            model_out[k] = 0;
            model_mot[k] = 1'b0;
        end
        model_ovr = 1'b0;
    endtask

    // One sweep: tick for one cycle, then check busy, overrun and every
    // channel's value/motion in each cycle, with the change due at 2+k cycles
    // after the tick cycle. extra_j (1..NCH+1) injects a dropped tick in that
    // cycle; perturb alters inputs after they must have been sampled.
    task automatic sweep(input int extra_j, input bit perturb);
        int old_v [NCH];
        int new_v [NCH];
        bit old_m [NCH];
        bit new_m [NCH];
        bit ovr0;
        for (int k = 0; k < NCH; k++) begin
            old_v[k] = model_out[k];
            old_m[k] = model_mot[k];
            new_v[k] = model_next(old_v[k], int'(in_set[k*DW +: DW]),
                                  int'(step_v[k*SW +: SW]), enable_v[k], wrap_v[k]);
            new_m[k] = (new_v[k] != int'(in_set[k*DW +: DW]));
        end
        ovr0 = model_ovr;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int j = 1; j <= NCH + 2; j++) begin
            check("busy", busy, (j <= NCH + 1) ? 32'd1 : 32'd0);
            check("overrun", overrun, (ovr0 || (extra_j > 0 && j > extra_j)) ? 32'd1 : 32'd0);
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("out%0d_c%0d", k, j), get_out(k),
                      (j >= 2 + k) ? new_v[k] : old_v[k]);
                check($sformatf("mot%0d_c%0d", k, j), motion[k],
                      (j >= 2 + k) ? new_m[k] : old_m[k]);
            end
            if (perturb && j == 2) in_set[0 +: DW] = DW'($urandom_range(0, FULL - 1));
            if (perturb && j == NCH + 1) begin
                for (int k = 0; k < NCH; k++) in_set[k*DW +: DW] = DW'($urandom_range(0, FULL - 1));
            end
            tick = (j == extra_j);
            if (j < NCH + 2) @(negedge clk);
        end
        tick = 1'b0;
        if (extra_j > 0) model_ovr = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            model_out[k] = new_v[k];
            model_mot[k] = new_m[k];
        end
    endtask

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        in_set   = '0;
        step_v   = '0;
        enable_v = '0;
        wrap_v   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        for (int k = 0; k < NCH; k++) check($sformatf("rst_out%0d", k), get_out(k), 0);
        check("rst_motion", motion, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_overrun", overrun, 32'd0);

        // Basic sweep, non-wrap, step 8
        set_ch(0, 20, 8, 1'b1, 1'b0);
        set_ch(1, 0, 8, 1'b1, 1'b0);
        set_ch(2, 65530, 8, 1'b1, 1'b0);
        set_ch(3, 5, 8, 1'b1, 1'b0);
        sweep(0, 1'b0);
        check("basic_out0", get_out(0), 8);
        check("basic_out1", get_out(1), 0);
        check("basic_out2", get_out(2), 8);
        check("basic_out3", get_out(3), 5);
        check("basic_motion", motion, 32'b0101);

        // Wrap climb through zero
        set_ch(0, 65530, 8, 1'b0, 1'b1);
        sweep(0, 1'b0);
        check("wrap_load", get_out(0), 65530);
        set_ch(0, 4, 4, 1'b1, 1'b1);
        sweep(0, 1'b0);
        check("wrap_t1", get_out(0), 65534);
        check("wrap_t1_mot", motion[0], 32'd1);
        sweep(0, 1'b0);
        check("wrap_t2", get_out(0), 2);
        sweep(0, 1'b0);
        check("wrap_t3", get_out(0), 4);
        check("wrap_t3_mot", motion[0], 32'd0);

        // Same move without wrap goes the long way down
        set_ch(0, 65530, 8, 1'b0, 1'b0);
        sweep(0, 1'b0);
        set_ch(0, 4, 4, 1'b1, 1'b0);
        sweep(0, 1'b0);
        check("nowrap_t1", get_out(0), 65526);

        // Bypass and zero step
        set_ch(2, 1234, 8, 1'b0, 1'b0);
        set_ch(1, 500, 0, 1'b1, 1'b0);
        sweep(0, 1'b0);
        check("bypass_out2", get_out(2), 1234);
        check("bypass_mot2", motion[2], 32'd0);
        check("step0_out1", get_out(1), 0);
        check("step0_mot1", motion[1], 32'd1);
        sweep(0, 1'b0);
        check("step0_hold", get_out(1), 0);

        // No overshoot; wrap half-range tie moves downward
        set_ch(3, 100, 8, 1'b0, 1'b0);
        set_ch(1, 0, 8, 1'b0, 1'b1);
        sweep(0, 1'b0);
        set_ch(3, 103, 8, 1'b1, 1'b0);
        set_ch(1, 32768, 8, 1'b1, 1'b1);
        sweep(0, 1'b0);
        check("overshoot", get_out(3), 103);
        check("tie_down", get_out(1), 65528);

        // Back-to-back ticks at nch+2 spacing never overrun; nch+1 does
        check("no_overrun", overrun, 32'd0);
        sweep(NCH + 1, 1'b0);
        check("overrun_set", overrun, 32'd1);
        sweep(0, 1'b0);
        check("overrun_sticky", overrun, 32'd1);

        // Reset in the third cycle of a sweep
        set_ch(0, 20, 8, 1'b1, 1'b0);
        set_ch(1, 0, 8, 1'b1, 1'b0);
        set_ch(2, 65530, 8, 1'b1, 1'b0);
        set_ch(3, 5, 8, 1'b1, 1'b0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < NCH; k++) check($sformatf("abort_out%0d", k), get_out(k), 0);
        check("abort_motion", motion, 32'd0);
        check("abort_busy", busy, 32'd0);
        check("abort_overrun", overrun, 32'd0);
        @(negedge clk);
        sweep(0, 1'b0);
        check("post_out0", get_out(0), 8);
        check("post_out2", get_out(2), 8);
        check("post_motion", motion, 32'b0101);

        // Randomized sweeps
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < NCH; k++) begin
                int sp;
                if ($urandom_range(0, 1) == 0)
                    sp = (model_out[k] + $urandom_range(0, 40) - 20 + FULL) % FULL;
                else
                    sp = $urandom_range(0, FULL - 1);
                set_ch(k, sp, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255),
                       ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1);
            end
            sweep(($urandom_range(0, 3) == 0) ? $urandom_range(1, NCH + 1) : 0,
                  $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
